prog_image_loader: RTL and testbench

//  Parametrised instruction/data memory for the core, replacing fixed per-program image modules.

---
 rtl/prog_image_loader_pkg.sv | 18 +
 rtl/prog_image_loader_if.sv | 36 +++
 rtl/prog_image_loader_sp_ram.sv | 29 ++
 rtl/prog_image_loader.sv | 136 +++++++++++++
 tb/tb_prog_image_loader.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_image_loader_pkg.sv
// Shared types and constants for the program image loader.
// Feature macro PROG_LOADER_CHECKSUM_EN enables the trailing checksum word.
package prog_mem_pkg;

  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CSUM = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

  function automatic logic [31:0] sum_wrap(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/prog_image_loader_if.sv
// Load stream, instruction fetch and data bus of the program image loader.
interface prog_image_loader_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INST_DEPTH = 64,
  parameter int unsigned DATA_DEPTH = 512
);
  localparam int unsigned IAW = $clog2(INST_DEPTH);
  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned CW  = $clog2(INST_DEPTH + 1);

  logic            load_req;
  logic            s_valid;
  logic            s_ready;
  logic [XLEN-1:0] s_data;
  logic [IAW-1:0]  inst_addr;
  logic [XLEN-1:0] inst_rdata;
  logic [DAW-1:0]  data_addr;
  logic            data_we;
  logic [XLEN-1:0] data_wdata;
  logic [XLEN-1:0] data_rdata;
  logic            cpu_run;
  logic            load_err;
  logic            csum_err;
  logic [CW-1:0]   word_count;

  modport slave (
    input  load_req, s_valid, s_data, inst_addr, data_addr, data_we, data_wdata,
    output s_ready, inst_rdata, data_rdata, cpu_run, load_err, csum_err, word_count
  );

  modport master (
    output load_req, s_valid, s_data, inst_addr, data_addr, data_we, data_wdata,
    input  s_ready, inst_rdata, data_rdata, cpu_run, load_err, csum_err, word_count
  );

endinterface

// File: rtl/prog_image_loader_sp_ram.sv
// Single write port, single synchronous read port RAM; collisions return old data.
module sp_ram #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [XLEN-1:0]          rdata_o
);
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_image_loader.sv
// Loads a program image into instruction RAM from a word stream, then releases the core.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum word after END_MARKER.
module prog_image_loader
  import prog_mem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INST_DEPTH = 64,
  parameter int unsigned DATA_DEPTH = 512
) (
  input logic              clk,
  input logic              rst,
  prog_image_loader_if.slave bus
);
  localparam int unsigned IAW = $clog2(INST_DEPTH);
  localparam int unsigned CW  = $clog2(INST_DEPTH + 1);

  loader_state_e state_q, state_d;
  logic [CW-1:0] wc_q, wc_d;
  logic          inst_we;
  logic          hs;
  logic          is_marker;
  logic          s_ready;

  assign s_ready   = (state_q == LOAD) || (state_q == CSUM);
  assign hs        = bus.s_valid & s_ready;
  assign is_marker = (bus.s_data == XLEN'(END_MARKER));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        csum_err_q, csum_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      csum_err_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      csum_err_q <= csum_err_d;
    end
  end

  always_comb begin
    sum_d      = sum_q;
    csum_err_d = csum_err_q;
    if (bus.load_req) begin
      sum_d      = '0;
      csum_err_d = 1'b0;
    end else if (state_q == LOAD && hs) begin
      sum_d = sum_wrap(sum_q, 32'(bus.s_data));
    end else if (state_q == CSUM && hs && bus.s_data != XLEN'(sum_q)) begin
      csum_err_d = 1'b1;
    end
  end

  assign bus.csum_err = csum_err_q;
`else
  assign bus.csum_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    inst_we = 1'b0;
    if (bus.load_req) begin
      state_d = LOAD;
      wc_d    = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (hs) begin
            inst_we = 1'b1;
            wc_d    = wc_q + CW'(1);
            // The marker wins even when it lands in the last slot.
            if (is_marker) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = RUN;
`endif
            end else if (wc_q == CW'(INST_DEPTH - 1)) begin
              state_d = ERR;
            end
          end
        end
        CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (hs) state_d = (bus.s_data == XLEN'(sum_q)) ? RUN : ERR;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.cpu_run    = (state_q == RUN);
  assign bus.load_err   = (state_q == ERR);
  assign bus.word_count = wc_q;

  sp_ram #(
    .XLEN (XLEN),
    .DEPTH(INST_DEPTH)
  ) u_inst_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (inst_we),
    .waddr_i(wc_q[IAW-1:0]),
    .wdata_i(bus.s_data),
    .raddr_i(bus.inst_addr),
    .rdata_o(bus.inst_rdata)
  );

  sp_ram #(
    .XLEN (XLEN),
    .DEPTH(DATA_DEPTH)
  ) u_data_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (bus.data_we),
    .waddr_i(bus.data_addr),
    .wdata_i(bus.data_wdata),
    .raddr_i(bus.data_addr),
    .rdata_o(bus.data_rdata)
  );

endmodule

// File: tb/tb_prog_image_loader.sv
// Directed bench for prog_image_loader with a behavioural image/memory model checked every cycle.
module tb_prog_image_loader;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_DEPTH = 64;
  localparam int unsigned DATA_DEPTH = 512;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prog_image_loader_if #(.XLEN(XLEN), .INST_DEPTH(INST_DEPTH), .DATA_DEPTH(DATA_DEPTH)) bus ();

  prog_image_loader #(.XLEN(XLEN), .INST_DEPTH(INST_DEPTH), .DATA_DEPTH(DATA_DEPTH)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: image = words accepted so far; phase 0 loading, 1 awaiting checksum, 2 running, 3 failed.
  logic [31:0] im [INST_DEPTH];
  bit          ik [INST_DEPTH];
  logic [31:0] dm [DATA_DEPTH];
  bit          dk [DATA_DEPTH];
  int          m_phase = 0;
  int          m_count = 0;
  logic [31:0] m_sum = '0;
  bit          m_cerr = 1'b0;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_data = '0;
  bit          exp_inst_v = 1'b0;
  bit          exp_data_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_count = 0; m_sum = '0; m_cerr = 1'b0;
      exp_inst = '0; exp_inst_v = 1'b1;
      exp_data = '0; exp_data_v = 1'b1;
    end else begin
      exp_inst_v = ik[bus.inst_addr]; exp_inst = im[bus.inst_addr];
      exp_data_v = dk[bus.data_addr]; exp_data = dm[bus.data_addr];
      if (bus.data_we) begin
        dm[bus.data_addr] = bus.data_wdata;
        dk[bus.data_addr] = 1'b1;
      end
      if (bus.load_req) begin
        m_phase = 0; m_count = 0; m_sum = '0; m_cerr = 1'b0;
      end else if (bus.s_valid && m_phase == 0) begin
        im[m_count] = bus.s_data;
        ik[m_count] = 1'b1;
        m_count++;
        m_sum = m_sum + bus.s_data;
        if (bus.s_data == 32'hFFFF_FFFF) m_phase = CS ? 1 : 2;
        else if (m_count == int'(INST_DEPTH)) m_phase = 3;
      end else if (bus.s_valid && m_phase == 1) begin
        if (bus.s_data == m_sum) m_phase = 2;
        else begin m_phase = 3; m_cerr = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    cmp("s_ready", 32'(bus.s_ready), 32'(m_phase == 0 || m_phase == 1));
    cmp("cpu_run", 32'(bus.cpu_run), 32'(m_phase == 2));
    cmp("load_err", 32'(bus.load_err), 32'(m_phase == 3));
    cmp("csum_err", 32'(bus.csum_err), 32'(m_cerr));
    cmp("word_count", 32'(bus.word_count), 32'(m_count));
    if (exp_inst_v) cmp("inst_rdata", bus.inst_rdata, exp_inst);
    if (exp_data_v) cmp("data_rdata", bus.data_rdata, exp_data);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  initial begin
    bus.load_req = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.inst_addr = '0; bus.data_addr = '0; bus.data_we = 1'b0; bus.data_wdata = '0;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cmp("reset s_ready", 32'(bus.s_ready), 32'd1);
    cmp("reset cpu_run", 32'(bus.cpu_run), 32'd0);
    cmp("reset word_count", 32'(bus.word_count), 32'd0);
    cmp("reset load_err", 32'(bus.load_err), 32'd0);
    cmp("reset inst_rdata", bus.inst_rdata, 32'h0);

    // Basic image
    push(32'h2001_0014); push(32'h0C00_000D); push(32'hFFFF_FFFF);
    if (CS) push(32'h2C01_0020);
    bus.inst_addr = 6'd1;
    cmp("t1 word_count", 32'(bus.word_count), 32'd3);
    cmp("t1 cpu_run", 32'(bus.cpu_run), 32'd1);
    tick();
    cmp("t1 fetch", bus.inst_rdata, 32'h0C00_000D);

    // Reload from RUN; load_req drops a same-cycle word
    bus.s_valid = 1'b1; bus.s_data = 32'h55;
    pulse_load_req();
    cmp("t3 cpu_run", 32'(bus.cpu_run), 32'd0);
    cmp("t3 word_count", 32'(bus.word_count), 32'd0);
    cmp("t3 s_ready", 32'(bus.s_ready), 32'd1);
    push(32'h11); push(32'hFFFF_FFFF);
    if (CS) push(32'h10);
    bus.inst_addr = 6'd0;
    cmp("t3 reload run", 32'(bus.cpu_run), 32'd1);
    cmp("t3 reload count", 32'(bus.word_count), 32'd2);
    tick();
    cmp("t3 fetch", bus.inst_rdata, 32'h11);

    // Data RAM read-old collision
    bus.data_addr = 9'd5; bus.data_we = 1'b1; bus.data_wdata = 32'h1111_1111;
    tick();
    bus.data_wdata = 32'hDEAD_BEEF;
    tick();
    bus.data_we = 1'b0;
    cmp("t4 collision", bus.data_rdata, 32'h1111_1111);
    tick();
    cmp("t4 readback", bus.data_rdata, 32'hDEAD_BEEF);

    // Overflow without marker
    pulse_load_req();
    for (int i = 0; i < int'(INST_DEPTH); i++) push(32'h1000 + 32'(i));
    cmp("t2 load_err", 32'(bus.load_err), 32'd1);
    cmp("t2 cpu_run", 32'(bus.cpu_run), 32'd0);
    cmp("t2 s_ready", 32'(bus.s_ready), 32'd0);
    cmp("t2 word_count", 32'(bus.word_count), 32'd64);
    bus.inst_addr = 6'd63;
    push(32'h77);
    cmp("t2 no accept", 32'(bus.word_count), 32'd64);
    cmp("t2 last word", bus.inst_rdata, 32'h103F);

    // Asynchronous reset mid-load
    pulse_load_req();
    push(32'hA0); push(32'hA1);
    bus.s_valid = 1'b1; bus.s_data = 32'hA2;
    #2 rst = 1'b1;
    #1;
    bus.s_valid = 1'b0;
    cmp("t5 s_ready", 32'(bus.s_ready), 32'd1);
    cmp("t5 word_count", 32'(bus.word_count), 32'd0);
    cmp("t5 load_err", 32'(bus.load_err), 32'd0);
    cmp("t5 inst_rdata", bus.inst_rdata, 32'h0);
    tick();
    rst = 1'b0;
    bus.inst_addr = 6'd0;
    push(32'hB0); push(32'hB1); push(32'hFFFF_FFFF);
    if (CS) push(32'h160);
    cmp("t5 reload run", 32'(bus.cpu_run), 32'd1);
    cmp("t5 reload count", 32'(bus.word_count), 32'd3);
    tick();
    cmp("t5 addr0 overwritten", bus.inst_rdata, 32'hB0);

    if (CS) begin
      pulse_load_req();
      push(32'h1); push(32'h2); push(32'hFFFF_FFFF); push(32'h2);
      cmp("t6 good run", 32'(bus.cpu_run), 32'd1);
      cmp("t6 good csum_err", 32'(bus.csum_err), 32'd0);
      pulse_load_req();
      push(32'h1); push(32'h2); push(32'hFFFF_FFFF); push(32'h3);
      cmp("t6 bad load_err", 32'(bus.load_err), 32'd1);
      cmp("t6 bad csum_err", 32'(bus.csum_err), 32'd1);
      cmp("t6 bad cpu_run", 32'(bus.cpu_run), 32'd0);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
